// File: rtl/multicycle_alu_if.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module  : multicycle_alu_if
// Brief   : Start/done request bus between the control FSM and multicycle_alu.
// Rev     : 1.0  initial release
//==============================================================================
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] ip_0;
    logic [WIDTH-1:0] ip_1;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] op_0;
    logic             change_pc;

    modport master (
        output start, opcode, ip_0, ip_1,
        input  busy, done, op_0, change_pc
    );

    modport slave (
        input  start, opcode, ip_0, ip_1,
        output busy, done, op_0, change_pc
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_alu.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module  : multicycle_alu
// Brief   : Registered ALU with start/done handshake; MUL is an iterative
//           shift-add that always runs exactly WIDTH steps.
// Rev     : 1.0  initial release
//==============================================================================
module multicycle_alu #(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_BLT = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    multicycle_alu_if.slave bus
);
    localparam int              c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [2:0] c_OP_MUL = 3'd0;
    localparam logic [2:0] c_OP_XOR = 3'd1;
    localparam logic [2:0] c_OP_BEQ = 3'd2;
    localparam logic [2:0] c_OP_BLT = 3'd3;
    localparam logic [2:0] c_OP_ADD = 3'd4;
    localparam logic [2:0] c_OP_SUB = 3'd5;
    localparam logic [2:0] c_OP_AND = 3'd6;
    localparam logic [2:0] c_OP_OR  = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_op_0;
    logic               r_change_pc;
    logic               r_done;

    logic [WIDTH-1:0]   w_mcand_nxt;
    logic [WIDTH-1:0]   w_mplier_nxt;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]   w_op_0_nxt;
    logic               w_change_pc_nxt;
    logic               w_done_nxt;

    logic [WIDTH-1:0]   w_acc_step;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_pc;
    logic               w_lt;

    generate
        if (SIGNED_BLT) begin : g_blt_signed
            assign w_lt = $signed(bus.ip_0) < $signed(bus.ip_1);
        end else begin : g_blt_unsigned
            assign w_lt = bus.ip_0 < bus.ip_1;
        end
    endgenerate

    // Single-cycle result path; MUL is handled by the iterative datapath.
    always_comb begin
        w_alu_res = '0;
        w_alu_pc  = 1'b0;
        case (bus.opcode)
            c_OP_XOR: w_alu_res = bus.ip_0 ^ bus.ip_1;
            c_OP_BEQ: w_alu_pc  = (bus.ip_0 == bus.ip_1);
            c_OP_BLT: w_alu_pc  = w_lt;
            c_OP_ADD: w_alu_res = bus.ip_0 + bus.ip_1;
            c_OP_SUB: w_alu_res = bus.ip_0 - bus.ip_1;
            c_OP_AND: w_alu_res = bus.ip_0 & bus.ip_1;
            c_OP_OR:  w_alu_res = bus.ip_0 | bus.ip_1;
            default:  w_alu_res = '0;
        endcase
    end

    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_state_nxt     = r_state;
        w_mcand_nxt     = r_mcand;
        w_mplier_nxt    = r_mplier;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_op_0_nxt      = r_op_0;
        w_change_pc_nxt = r_change_pc;
        w_done_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.opcode == c_OP_MUL) begin
                        w_mcand_nxt  = bus.ip_0;
                        w_mplier_nxt = bus.ip_1;
                        w_acc_nxt    = '0;
                        w_cnt_nxt    = c_CNT_INIT;
                        w_state_nxt  = ST_MUL;
                    end else begin
                        w_op_0_nxt      = w_alu_res;
                        w_change_pc_nxt = w_alu_pc;
                        w_done_nxt      = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // start is deliberately not looked at here: no queueing while busy.
                w_acc_nxt    = w_acc_step;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt - c_CNT_ONE;
                if (r_cnt == c_CNT_ONE) begin
                    w_op_0_nxt      = w_acc_step;
                    w_change_pc_nxt = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_op_0      <= '0;
            r_change_pc <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mcand     <= w_mcand_nxt;
            r_mplier    <= w_mplier_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_op_0      <= w_op_0_nxt;
            r_change_pc <= w_change_pc_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.busy      = (r_state == ST_MUL);
    assign bus.done      = r_done;
    assign bus.op_0      = r_op_0;
    assign bus.change_pc = r_change_pc;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module  : tb_multicycle_alu
// Brief   : Bench for three multicycle_alu lanes (32u, 32s, 8u) against a model.
// Rev     : 1.0  initial release
//==============================================================================
module tb_multicycle_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st32 = 1'b0;
    logic        st8  = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    multicycle_alu_if #(.WIDTH(32)) bus_u ();
    multicycle_alu_if #(.WIDTH(32)) bus_s ();
    multicycle_alu_if #(.WIDTH(8))  bus_b ();

    assign bus_u.start = st32;  assign bus_u.opcode = op;
    assign bus_u.ip_0  = a;     assign bus_u.ip_1   = b;
    assign bus_s.start = st32;  assign bus_s.opcode = op;
    assign bus_s.ip_0  = a;     assign bus_s.ip_1   = b;
    assign bus_b.start = st8;   assign bus_b.opcode = op;
    assign bus_b.ip_0  = a[7:0]; assign bus_b.ip_1  = b[7:0];

    multicycle_alu #(.WIDTH(32), .SIGNED_BLT(1'b0)) u_dut_u (.clk(clk), .rst(rst), .bus(bus_u));
    multicycle_alu #(.WIDTH(32), .SIGNED_BLT(1'b1)) u_dut_s (.clk(clk), .rst(rst), .bus(bus_s));
    multicycle_alu #(.WIDTH(8),  .SIGNED_BLT(1'b0)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        logic [31:0] res;
        bit          pc;
        int          lat;
        int          t0;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    function automatic int lane_w(input int l);
        return (l == 2) ? 8 : 32;
    endfunction

    // Reference arithmetic: plain wide integer maths reduced modulo 2^w.
    function automatic void alu_model(input int w, input bit sgn, input logic [2:0] opc,
                                      input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] r, output bit p);
        longint unsigned mask, xa, ya;
        longint          sx, sy;
        mask = (64'd1 << w) - 64'd1;
        xa   = longint'(x) & mask;
        ya   = longint'(y) & mask;
        sx   = ((xa >> (w - 1)) & 64'd1) != 0 ? longint'(xa) - longint'(64'd1 << w) : longint'(xa);
        sy   = ((ya >> (w - 1)) & 64'd1) != 0 ? longint'(ya) - longint'(64'd1 << w) : longint'(ya);
        r = '0;
        p = 1'b0;
        case (opc)
            3'd0: r = 32'((xa * ya) & mask);
            3'd1: r = 32'(xa ^ ya);
            3'd2: p = (xa == ya);
            3'd3: p = sgn ? (sx < sy) : (xa < ya);
            3'd4: r = 32'((xa + ya) & mask);
            3'd5: r = 32'((xa - ya) & mask);
            3'd6: r = 32'(xa & ya);
            default: r = 32'(xa | ya);
        endcase
    endfunction

    // Model state per lane: remaining multiply cycles, visible outputs.
    int          m_cnt [3];
    logic [31:0] m_res [3];
    logic [31:0] m_pend[3];
    bit          m_pc  [3];
    bit          m_done[3];

    always @(posedge clk or posedge rst) begin : p_model
        logic [31:0] r;
        bit          p;
        bit          sl;
        for (int l = 0; l < 3; l++) begin
            sl = (l == 2) ? st8 : st32;
            if (rst) begin
                m_cnt[l]  = 0;
                m_res[l]  = '0;
                m_pc[l]   = 1'b0;
                m_done[l] = 1'b0;
            end else begin
                m_done[l] = 1'b0;
                if (m_cnt[l] > 0) begin
                    m_cnt[l]--;
                    if (m_cnt[l] == 0) begin
                        m_done[l] = 1'b1;
                        m_res[l]  = m_pend[l];
                        m_pc[l]   = 1'b0;
                    end
                end else if (sl) begin
                    alu_model(lane_w(l), (l == 1), op, a, b, r, p);
                    if (op == 3'd0) begin
                        m_pend[l] = r;
                        m_cnt[l]  = lane_w(l);
                    end else begin
                        m_done[l] = 1'b1;
                        m_res[l]  = r;
                        m_pc[l]   = p;
                    end
                end
            end
        end
    end

    task automatic chk(input int l, input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL lane%0d %s cyc=%0d got=%h exp=%h", l, nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin : p_compare
        logic        d_done, d_busy, d_pc, have;
        logic [31:0] d_res;
        exp_t        e;
        for (int l = 0; l < 3; l++) begin
            case (l)
                0: begin d_done = bus_u.done; d_busy = bus_u.busy; d_res = bus_u.op_0; d_pc = bus_u.change_pc; end
                1: begin d_done = bus_s.done; d_busy = bus_s.busy; d_res = bus_s.op_0; d_pc = bus_s.change_pc; end
                default: begin d_done = bus_b.done; d_busy = bus_b.busy; d_res = 32'(bus_b.op_0); d_pc = bus_b.change_pc; end
            endcase
            chk(l, "done",      32'(d_done), 32'(m_done[l]));
            chk(l, "busy",      32'(d_busy), 32'(m_cnt[l] > 0));
            chk(l, "op_0",      d_res,       m_res[l]);
            chk(l, "change_pc", 32'(d_pc),   32'(m_pc[l]));
            if (d_done) begin
                have = 1'b0;
                case (l)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                endcase
                if (!have) begin
                    chk(l, "unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk(l, "lit_result",  d_res,         e.res);
                    chk(l, "lit_pc",      32'(d_pc),     32'(e.pc));
                    chk(l, "lit_latency", 32'(cyc - e.t0), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] r, input bit p0, input bit p1, input int lat);
        exp_t e;
        op = o; a = x; b = y; st32 = 1'b1;
        e.res = r; e.pc = p0; e.lat = lat; e.t0 = cyc;
        q0.push_back(e);
        e.pc = p1;
        q1.push_back(e);
        @(posedge clk); #1;
        st32 = 1'b0;
    endtask

    task automatic issue8(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] r, input int lat);
        exp_t e;
        op = o; a = x; b = y; st8 = 1'b1;
        e.res = r; e.pc = 1'b0; e.lat = lat; e.t0 = cyc;
        q2.push_back(e);
        @(posedge clk); #1;
        st8 = 1'b0;
    endtask

    // Start that must leave no completion of its own (ignored or reset away).
    task automatic poke32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; st32 = 1'b1;
        @(posedge clk); #1;
        st32 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        issue32(3'd4, 32'hFFFF_FFFF, 32'h1,    32'h0,         1'b0, 1'b0, 1);
        issue32(3'd5, 32'h3,         32'h5,    32'hFFFF_FFFE, 1'b0, 1'b0, 1);
        issue32(3'd6, 32'hF0F0,      32'hFF00, 32'hF000,      1'b0, 1'b0, 1);
        issue32(3'd7, 32'hF0F0,      32'hFF00, 32'hFFF0,      1'b0, 1'b0, 1);
        issue32(3'd1, 32'hFF,        32'h0F,   32'hF0,        1'b0, 1'b0, 1);
        issue32(3'd2, 32'h7,         32'h7,    32'h0,         1'b1, 1'b1, 1);
        issue32(3'd2, 32'h7,         32'h8,    32'h0,         1'b0, 1'b0, 1);
        issue32(3'd3, 32'hFFFF_FFFF, 32'h1,    32'h0,         1'b0, 1'b1, 1);
        issue32(3'd3, 32'h1,         32'hFFFF_FFFF, 32'h0,    1'b1, 1'b0, 1);
        repeat (2) @(posedge clk);
        #1;
        issue32(3'd0, 32'h0001_0003, 32'h5, 32'h0005_000F, 1'b0, 1'b0, 33);
        repeat (33) @(posedge clk);
        #1;
        issue32(3'd0, 32'h8000_0000, 32'h2, 32'h0, 1'b0, 1'b0, 33);
        repeat (33) @(posedge clk);
        #1;
        issue32(3'd0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 33);
        repeat (33) @(posedge clk);
        #1;
        // ADD poked mid-multiply is dropped; ADD in the done cycle is taken.
        issue32(3'd0, 32'h7, 32'h9, 32'd63, 1'b0, 1'b0, 33);
        repeat (5) @(posedge clk);
        #1;
        poke32(3'd4, 32'h1, 32'h1);
        repeat (26) @(posedge clk);
        #1;
        issue32(3'd4, 32'h2, 32'h3, 32'h5, 1'b0, 1'b0, 1);
        repeat (3) @(posedge clk);
        #1;
        poke32(3'd0, 32'h3, 32'h4);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        issue32(3'd4, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1);
        repeat (2) @(posedge clk);
        #1;
        issue8(3'd0, 32'd15, 32'd17, 32'hFF, 9);
        repeat (8) @(posedge clk);
        #1;
        issue8(3'd4, 32'hFF, 32'h2, 32'h01, 1);
        issue8(3'd5, 32'h1, 32'h2, 32'hFF, 1);
        for (int i = 0; i < 100 && (q0.size() + q1.size() + q2.size()) != 0; i++)
            @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk(-1, "pending_expectations", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
